// File: rtl/memory_access_stage.sv
// MEM stage: drives the data-memory req/ack bus, aligns stores, extends loads,
// and owns the MEM/WB pipeline register. stall_o freezes upstream stages mid-access.
module memory_access_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        em_reg_write_i,
  input  logic        em_mem_read_i,
  input  logic        em_mem_write_i,
  input  logic [1:0]  em_dmem_to_reg_i,
  input  logic [2:0]  em_funct3_i,
  input  logic [4:0]  em_write_addr_i,
  input  logic [31:0] em_alu_result_i,
  input  logic [31:0] em_read_data2_i,
  input  logic [31:0] em_pc_new_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_be_o,
  input  logic [31:0] dmem_rdata_i,
  input  logic        dmem_ack_i,
  output logic        stall_o,
  output logic        mw_reg_write_o,
  output logic [1:0]  mw_dmem_to_reg_o,
  output logic [4:0]  mw_write_addr_o,
  output logic [31:0] mw_alu_result_o,
  output logic [31:0] mw_load_data_o,
  output logic [31:0] mw_pc_new_o,
  output logic        misalign_o,
  output logic        bus_error_o
);

  localparam int unsigned CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;

  logic        access, is_load, is_byte, is_half, is_word, misaligned;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc, load_ext;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        misalign_hit, timeout_hit, ack_done;

  assign access     = em_mem_read_i | em_mem_write_i;
  assign is_load    = em_mem_read_i & ~em_mem_write_i;
  assign is_byte    = (em_funct3_i[1:0] == 2'b00);
  assign is_half    = (em_funct3_i[1:0] == 2'b01);
  assign is_word    = ~is_byte & ~is_half;
  assign misaligned = (is_half & em_alu_result_i[0]) |
                      (is_word & (em_alu_result_i[1:0] != 2'b00));

  always_comb begin
    be_calc    = 4'b1111;
    wdata_calc = em_read_data2_i;
    if (is_byte) begin
      be_calc    = 4'b0001 << em_alu_result_i[1:0];
      wdata_calc = {4{em_read_data2_i[7:0]}};
    end else if (is_half) begin
      be_calc    = em_alu_result_i[1] ? 4'b1100 : 4'b0011;
      wdata_calc = {2{em_read_data2_i[15:0]}};
    end
  end

  always_comb begin
    ld_byte = dmem_rdata_i[7:0];
    case (em_alu_result_i[1:0])
      2'd1:    ld_byte = dmem_rdata_i[15:8];
      2'd2:    ld_byte = dmem_rdata_i[23:16];
      2'd3:    ld_byte = dmem_rdata_i[31:24];
      default: ld_byte = dmem_rdata_i[7:0];
    endcase
    ld_half  = em_alu_result_i[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    load_ext = dmem_rdata_i;
    if (is_byte)
      load_ext = {{24{ld_byte[7] & ~em_funct3_i[2]}}, ld_byte};
    else if (is_half)
      load_ext = {{16{ld_half[15] & ~em_funct3_i[2]}}, ld_half};
  end

  always_comb begin
    state_d      = state_q;
    stall_o      = 1'b0;
    misalign_hit = 1'b0;
    timeout_hit  = 1'b0;
    ack_done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          if (misaligned) begin
            misalign_hit = 1'b1;
          end else begin
            state_d = BUSY;
            stall_o = 1'b1;
          end
        end
      end
      BUSY: begin
        if (dmem_ack_i) begin
          state_d  = IDLE;
          ack_done = 1'b1;
        end else if (cnt_q == LAST_CNT) begin
          state_d     = IDLE;
          timeout_hit = 1'b1;
        end else begin
          stall_o = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs decode straight from the state so IDLE drives an all-zero bus.
  always_comb begin
    dmem_req_o   = (state_q == BUSY);
    dmem_we_o    = dmem_req_o & em_mem_write_i;
    dmem_addr_o  = dmem_req_o ? {em_alu_result_i[31:2], 2'b00} : '0;
    dmem_wdata_o = dmem_req_o ? wdata_calc : '0;
    dmem_be_o    = dmem_req_o ? be_calc : '0;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      misalign_o       <= 1'b0;
      bus_error_o      <= 1'b0;
      mw_reg_write_o   <= 1'b0;
      mw_dmem_to_reg_o <= '0;
      mw_write_addr_o  <= '0;
      mw_alu_result_o  <= '0;
      mw_load_data_o   <= '0;
      mw_pc_new_o      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= (state_q == BUSY && state_d == BUSY) ? cnt_q + 1'b1 : '0;
      misalign_o  <= misalign_hit;
      bus_error_o <= timeout_hit;
      if (stall_o) begin
        mw_reg_write_o <= 1'b0;
      end else begin
        mw_reg_write_o   <= em_reg_write_i & ~misalign_hit & ~timeout_hit;
        mw_dmem_to_reg_o <= em_dmem_to_reg_i;
        mw_write_addr_o  <= em_write_addr_i;
        mw_alu_result_o  <= em_alu_result_i;
        mw_load_data_o   <= (ack_done & is_load) ? load_ext : '0;
        mw_pc_new_o      <= em_pc_new_i;
      end
    end
  end

endmodule
